// File: rtl/mem_bus_pkg.sv
// Shared bus definitions for the physical memory arbiter: widths, owner ids and FSM encoding.
package mem_bus_pkg;
    localparam int ADDR_W = 32;
    localparam int DAT_W  = 32;
    localparam int SEL_W  = 4;

    localparam logic OWNER_M0 = 1'b0;
    localparam logic OWNER_M1 = 1'b1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;
endpackage

// File: rtl/bus_timeout.sv
// Cycle counter for an outstanding bus transaction; o_expire fires on the last allowed cycle.
module bus_timeout #(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);
    localparam logic [TO_W-1:0] LAST_CNT = TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    // TIMEOUT of zero disables expiry entirely.
    assign o_expire = (TIMEOUT != 0) && i_en && (cnt_q == LAST_CNT);
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising the fetch (m0) and data (m1) translators onto one slave bus.
module mem_arbiter
    import mem_bus_pkg::*;
#(
    parameter int TIMEOUT = 1024,
    parameter int TO_W    = 11
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [ADDR_W-1:0] i_m0_addr,
    input  logic              i_m0_stb,
    input  logic [SEL_W-1:0]  i_m0_we,
    input  logic [DAT_W-1:0]  i_m0_dat_w,
    output logic              o_m0_ack,
    output logic              o_m0_err,
    output logic [DAT_W-1:0]  o_m0_dat_r,
    input  logic [ADDR_W-1:0] i_m1_addr,
    input  logic              i_m1_stb,
    input  logic [SEL_W-1:0]  i_m1_we,
    input  logic [DAT_W-1:0]  i_m1_dat_w,
    output logic              o_m1_ack,
    output logic              o_m1_err,
    output logic [DAT_W-1:0]  o_m1_dat_r,
    output logic [ADDR_W-1:0] o_addr,
    output logic              o_stb,
    output logic [SEL_W-1:0]  o_we,
    output logic [DAT_W-1:0]  o_dat_w,
    input  logic              i_ack,
    input  logic [DAT_W-1:0]  i_dat_r
);
    state_e     state_q;
    logic       owner_q;
    logic       last_q;
    logic [1:0] pending_q;
    logic [1:0] pending_d;
    logic       stb_q;
    logic [1:0] err_q;

    logic       busy;
    logic [1:0] req;
    logic       winner;
    logic       grant;
    logic       expire;

    assign busy   = (state_q == ST_BUSY);
    assign req    = pending_q | {i_m1_stb, i_m0_stb};
    assign winner = (req == 2'b11) ? ~last_q : req[1];
    assign grant  = !busy && (req != 2'b00);

    // The owner re-strobing mid-transaction is a protocol violation and is dropped.
    always_comb begin
        pending_d = pending_q | {i_m1_stb, i_m0_stb};
        if (busy)
            pending_d[owner_q] = pending_q[owner_q];
        if (grant)
            pending_d[winner] = 1'b0;
    end

    bus_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_clr    (grant),
        .i_en     (busy && !i_ack),
        .o_expire (expire)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            owner_q   <= OWNER_M0;
            last_q    <= OWNER_M1;
            pending_q <= 2'b00;
            stb_q     <= 1'b0;
            err_q     <= 2'b00;
        end else begin
            pending_q <= pending_d;
            stb_q     <= grant;
            err_q     <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (grant) begin
                        owner_q <= winner;
                        state_q <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    // An ack on the expiry cycle takes precedence over the error.
                    if (i_ack) begin
                        state_q <= ST_IDLE;
                        last_q  <= owner_q;
                    end else if (expire) begin
                        err_q[owner_q] <= 1'b1;
                        state_q        <= ST_IDLE;
                        last_q         <= owner_q;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign o_stb   = stb_q;
    assign o_addr  = (owner_q == OWNER_M1) ? i_m1_addr  : i_m0_addr;
    assign o_dat_w = (owner_q == OWNER_M1) ? i_m1_dat_w : i_m0_dat_w;
    assign o_we    = !busy ? '0 : ((owner_q == OWNER_M1) ? i_m1_we : i_m0_we);

    assign o_m0_ack   = busy && i_ack && (owner_q == OWNER_M0);
    assign o_m1_ack   = busy && i_ack && (owner_q == OWNER_M1);
    assign o_m0_err   = err_q[0];
    assign o_m1_err   = err_q[1];
    assign o_m0_dat_r = i_dat_r;
    assign o_m1_dat_r = i_dat_r;
endmodule
